// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one instruction at a time, fetches operands from a single-port
// register file, holds them on the ALU for the op-dependent settle time, and writes back.
module alu_sequencer #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [4:0]  rf_addr,
    output logic        rf_we,
    output logic [15:0] rf_wdata,
    input  logic [15:0] rf_rdata,
    output logic [5:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic        illegal
);
    // state | meaning
    // IDLE  | waiting for an instruction, instr_ready high
    // RDA   | rf_addr = rsrc1
    // RDB   | capture a, rf_addr = rsrc2
    // CAP   | capture the last fetched operand
    // EXEC  | operands held on the ALU until the settle count expires
    // WB1   | write result[15:0] to rdst1
    // WB2   | write result[31:16] to rdst2 (MUL only)
    // ERR   | unsupported opcode, done + illegal, no write
    typedef enum logic [2:0] {IDLE, RDA, RDB, CAP, EXEC, WB1, WB2, ERR} state_t;

    localparam logic [5:0] OP_MOVI = 6'b000000;
    localparam logic [5:0] OP_MOVR = 6'b000001;
    localparam logic [5:0] OP_NEG  = 6'b000110;
    localparam logic [5:0] OP_MUL  = 6'b000111;
    localparam logic [5:0] OP_DIV  = 6'b001000;
    localparam logic [5:0] OP_NOT  = 6'b001110;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

    function automatic logic is_two(input logic [5:0] op);
        case (op)
            6'b000100, 6'b000101, 6'b000111, 6'b001000, 6'b001001, 6'b001010,
            6'b001011, 6'b001100, 6'b001101, 6'b001111, 6'b010000: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_one(input logic [5:0] op);
        return (op == OP_MOVR) || (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic [CNT_W-1:0] exec_cnt(input logic [5:0] op);
        case (op)
            OP_MUL:  return MUL_CNT;
            OP_DIV:  return DIV_CNT;
            default: return CNT_ONE;
        endcase
    endfunction

    state_t           state, state_n;
    logic [5:0]       op_q;
    logic [4:0]       rdst1_q, rsrc1_q, rsrc2_q, rdst2_q;
    logic [15:0]      imm_q, a_q, b_q;
    logic [31:0]      result_q;
    logic [CNT_W-1:0] cnt_q;
    logic [5:0]       in_op;
    logic             we_c, done_c, ill_c;

    assign in_op = instr[31:26];

    always_comb begin
        state_n  = state;
        rf_addr  = '0;
        rf_wdata = '0;
        we_c     = 1'b0;
        done_c   = 1'b0;
        ill_c    = 1'b0;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    if (in_op == OP_MOVI)                     state_n = EXEC;
                    else if (is_two(in_op) || is_one(in_op))  state_n = RDA;
                    else                                      state_n = ERR;
                end
            end
            RDA: begin
                rf_addr = rsrc1_q;
                state_n = is_two(op_q) ? RDB : CAP;
            end
            RDB: begin
                rf_addr = rsrc2_q;
                state_n = CAP;
            end
            CAP:  state_n = EXEC;
            EXEC: if (cnt_q <= CNT_ONE) state_n = WB1;
            WB1: begin
                we_c     = 1'b1;
                rf_addr  = rdst1_q;
                rf_wdata = result_q[15:0];
                if (op_q == OP_MUL) begin
                    state_n = WB2;
                end else begin
                    done_c  = 1'b1;
                    state_n = IDLE;
                end
            end
            WB2: begin
                we_c     = 1'b1;
                rf_addr  = rdst2_q;
                rf_wdata = result_q[31:16];
                done_c   = 1'b1;
                state_n  = IDLE;
            end
            ERR: begin
                done_c  = 1'b1;
                ill_c   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= '0;
            rdst1_q  <= '0;
            rsrc1_q  <= '0;
            rsrc2_q  <= '0;
            rdst2_q  <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        op_q     <= in_op;
                        rdst1_q  <= instr[25:21];
                        rsrc1_q  <= instr[20:16];
                        rsrc2_q  <= instr[15:11];
                        rdst2_q  <= instr[10:6];
                        imm_q    <= instr[15:0];
                        a_q      <= '0;
                        b_q      <= '0;
                        result_q <= '0;
                        cnt_q    <= CNT_ONE;
                    end
                end
                RDB: a_q <= rf_rdata;
                CAP: begin
                    if (is_two(op_q)) b_q <= rf_rdata;
                    else              a_q <= rf_rdata;
                    cnt_q <= exec_cnt(op_q);
                end
                EXEC: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    // sample the ALU only once it has settled for the full count
                    if (cnt_q <= CNT_ONE) begin
                        if (op_q == OP_MOVI)      result_q <= {16'h0000, imm_q};
                        else if (op_q == OP_MOVR) result_q <= {16'h0000, a_q};
                        else                      result_q <= alu_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign alu_op      = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign rf_we       = we_c & ~reset;
    assign done        = done_c & ~reset;
    assign illegal     = ill_c & ~reset;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: register-file and ALU stand-ins, an instruction-level
// reference model, a per-cycle output compare, directed cases and random traffic.
module tb_alu_sequencer;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;

    localparam logic [5:0] OP_MOVI = 6'b000000;
    localparam logic [5:0] OP_MOVR = 6'b000001;
    localparam logic [5:0] OP_ADD  = 6'b000100;
    localparam logic [5:0] OP_SUB  = 6'b000101;
    localparam logic [5:0] OP_NEG  = 6'b000110;
    localparam logic [5:0] OP_MUL  = 6'b000111;
    localparam logic [5:0] OP_DIV  = 6'b001000;
    localparam logic [5:0] OP_OR   = 6'b001001;
    localparam logic [5:0] OP_XOR  = 6'b001010;
    localparam logic [5:0] OP_NAND = 6'b001011;
    localparam logic [5:0] OP_NOR  = 6'b001100;
    localparam logic [5:0] OP_XNOR = 6'b001101;
    localparam logic [5:0] OP_NOT  = 6'b001110;
    localparam logic [5:0] OP_LLSH = 6'b001111;
    localparam logic [5:0] OP_LRSH = 6'b010000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready, rf_we, busy, done, illegal;
    logic [4:0]  rf_addr;
    logic [15:0] rf_wdata, rf_rdata, alu_a, alu_b;
    logic [5:0]  alu_op;
    logic [31:0] alu_result;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clock = ~clock;

    alu_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .busy(busy), .done(done), .illegal(illegal)
    );

    function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            OP_ADD:  return {16'h0, a + b};
            OP_SUB:  return {16'h0, b + ~a};
            OP_MUL:  return {16'h0, a} * {16'h0, b};
            OP_DIV:  return (b == 16'h0) ? 32'hFFFF_FFFF : {16'h0, a / b};
            OP_OR:   return {16'h0, a | b};
            OP_XOR:  return {16'h0, a ^ b};
            OP_NAND: return {16'h0, ~(a & b)};
            OP_NOR:  return {16'h0, ~(a | b)};
            OP_XNOR: return {16'h0, ~(a ^ b)};
            OP_LLSH: return {16'h0, a << b[3:0]};
            OP_LRSH: return {16'h0, a >> b[3:0]};
            OP_NEG:  return {16'h0, 16'h0 - a};
            OP_NOT:  return {16'h0, ~a};
            default: return 32'h0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    // Register file stand-in: registered read, write on rf_we, bench backdoor poke.
    logic [15:0] mem [32];
    logic        poke_en = 1'b0;
    logic [4:0]  poke_addr = '0;
    logic [15:0] poke_data = '0;
    always @(posedge clock) begin
        if (poke_en)    mem[poke_addr] <= poke_data;
        else if (rf_we) mem[rf_addr]   <= rf_wdata;
        rf_rdata <= mem[rf_addr];
    end

    // 2 = two-operand, 1 = one-operand, 0 = MOV-imm, -1 = illegal
    function automatic int op_class(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_OR, OP_XOR, OP_NAND, OP_NOR,
            OP_XNOR, OP_LLSH, OP_LRSH: return 2;
            OP_MOVR, OP_NEG, OP_NOT:   return 1;
            OP_MOVI:                   return 0;
            default:                   return -1;
        endcase
    endfunction

    // Instruction-level model: at accept it schedules every visible event of the instruction.
    logic [15:0] rmodel [32];
    bit          m_pend = 1'b0;
    int          m_acc = 0, m_L = 0, m_ex0 = 0, m_E = 0, m_wb1 = -1, m_wb2 = -1;
    logic [5:0]  m_op = '0;
    logic [4:0]  m_d1 = '0, m_d2 = '0;
    logic [15:0] m_a = '0, m_b = '0;
    logic [31:0] m_res = '0;
    bit          m_ill = 1'b0, m_movi = 1'b0;

    always @(posedge clock) begin : model_p
        int n, cls;
        n = cyc;
        if (poke_en) rmodel[poke_addr] = poke_data;
        if (reset) begin
            m_pend = 1'b0;
        end else begin
            if (m_pend && n == m_wb1) rmodel[m_d1] = m_res[15:0];
            if (m_pend && n == m_wb2) rmodel[m_d2] = m_res[31:16];
            if ((!m_pend || n > m_acc + m_L) && instr_valid) begin
                m_pend = 1'b1;
                m_acc  = n;
                m_op   = instr[31:26];
                m_d1   = instr[25:21];
                m_d2   = instr[10:6];
                cls    = op_class(m_op);
                m_ill  = (cls < 0);
                m_movi = (cls == 0);
                m_a    = (cls >= 1) ? rmodel[instr[20:16]] : 16'h0;
                m_b    = (cls == 2) ? rmodel[instr[15:11]] : 16'h0;
                m_E    = (m_op == OP_MUL) ? MUL_LAT : (m_op == OP_DIV) ? DIV_LAT : 1;
                m_wb2  = -1;
                if (m_ill) begin
                    m_E = 0; m_ex0 = -100; m_wb1 = -1; m_L = 1;
                end else begin
                    m_ex0 = n + ((cls == 2) ? 4 : (cls == 1) ? 3 : 1);
                    m_wb1 = m_ex0 + m_E;
                    if (m_op == OP_MUL) m_wb2 = m_wb1 + 1;
                    m_L   = ((m_wb2 >= 0) ? m_wb2 : m_wb1) - n;
                end
                if (m_movi)               m_res = {16'h0, instr[15:0]};
                else if (m_op == OP_MOVR) m_res = {16'h0, m_a};
                else                      m_res = alu_f(m_op, m_a, m_b);
            end
        end
        cyc = n + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired, got no event expected one (cycle %0d)", nm, cyc);
    endtask

    // Per-cycle compare, sampled mid-cycle after the stimulus has settled.
    initial begin : compare_p
        bit prev_rst;
        int c;
        bit e_busy, e_done, e_we;
        prev_rst = 1'b1;
        forever begin
            @(negedge clock);
            #2;
            c = cyc;
            if (reset) begin
                chk("rst_rf_we", rf_we, 0);
                chk("rst_done", done, 0);
                chk("rst_illegal", illegal, 0);
            end else begin
                e_busy = m_pend && c > m_acc && c <= m_acc + m_L;
                e_done = m_pend && c == m_acc + m_L;
                e_we   = m_pend && (c == m_wb1 || c == m_wb2);
                chk("busy", busy, e_busy);
                chk("ready", instr_ready, !e_busy);
                chk("done", done, e_done);
                chk("illegal", illegal, e_done && m_ill);
                chk("rf_we", rf_we, e_we);
                if (e_we) begin
                    chk("rf_addr", rf_addr, (c == m_wb1) ? m_d1 : m_d2);
                    chk("rf_wdata", rf_wdata, (c == m_wb1) ? m_res[15:0] : m_res[31:16]);
                end
                if (m_pend && c >= m_ex0 && c < m_ex0 + m_E) begin
                    chk("alu_op_hold", alu_op, m_op);
                    if (!m_movi) begin
                        chk("alu_a_hold", alu_a, m_a);
                        chk("alu_b_hold", alu_b, m_b);
                    end
                end
                if (prev_rst) begin
                    chk("rst_alu_op", alu_op, 0);
                    chk("rst_alu_a", alu_a, 0);
                    chk("rst_alu_b", alu_b, 0);
                    chk("rst_rf_addr", rf_addr, 0);
                    chk("rst_rf_wdata", rf_wdata, 0);
                end
            end
            prev_rst = reset;
        end
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] d1,
                                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d2);
        return {op, d1, s1, s2, d2, 6'b000000};
    endfunction

    function automatic logic [5:0] pick_op(input int i);
        case (i)
            0: return OP_MOVI;  1: return OP_MOVR;  2: return OP_ADD;   3: return OP_SUB;
            4: return OP_NEG;   5: return OP_MUL;   6: return OP_DIV;   7: return OP_OR;
            8: return OP_XOR;   9: return OP_NAND; 10: return OP_NOR;  11: return OP_XNOR;
            12: return OP_NOT; 13: return OP_LLSH; 14: return OP_LRSH;
            default: return 6'($urandom);
        endcase
    endfunction

    task automatic poke(input logic [4:0] a, input logic [15:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clock);
        poke_en = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the cycle after done.
    task automatic issue(input logic [31:0] w, input logic [31:0] next_w, input bit hold,
                         output int acc, output int lat);
        acc = -1; lat = -1;
        instr = w; instr_valid = 1'b1;
        for (int t = 0; t < 40 && acc < 0; t++) begin
            if (instr_ready) acc = cyc;
            else @(negedge clock);
        end
        if (acc < 0) begin
            fail("accept_timeout");
            instr_valid = 1'b0;
            return;
        end
        @(negedge clock);
        if (hold) instr = next_w;
        else      instr_valid = 1'b0;
        for (int t = 0; t < 40 && lat < 0; t++) begin
            if (done) lat = cyc - acc;
            else @(negedge clock);
        end
        if (lat < 0) fail("done_timeout");
        @(negedge clock);
    endtask

    initial begin : stim_p
        int acc, lat, acc2, lat2;
        logic [15:0] keep1, keep2;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 32; i++) poke(5'(i), 16'($urandom));
        reset = 1'b0;
        @(negedge clock);
        chk("idle_ready", instr_ready, 1);
        chk("idle_busy", busy, 0);

        poke(5'd3, 16'd5); poke(5'd4, 16'd7);
        issue(mk(OP_ADD, 5'd1, 5'd3, 5'd4, 5'd0), 32'h0, 1'b0, acc, lat);
        chk("add_latency", lat, 5);
        chk("add_r1", mem[1], 16'h000C);

        poke(5'd3, 16'h1234); poke(5'd4, 16'h0100);
        issue(mk(OP_MUL, 5'd1, 5'd3, 5'd4, 5'd2), 32'h0, 1'b0, acc, lat);
        chk("mul_latency", lat, 7);
        chk("mul_r1_lo", mem[1], 16'h3400);
        chk("mul_r2_hi", mem[2], 16'h0012);

        issue({OP_MOVI, 5'd5, 5'd0, 16'hBEEF}, 32'h0, 1'b0, acc, lat);
        chk("movi_latency", lat, 2);
        chk("movi_r5", mem[5], 16'hBEEF);

        issue(mk(6'b111111, 5'd7, 5'd1, 5'd2, 5'd3), 32'h0, 1'b0, acc, lat);
        chk("illegal_latency", lat, 1);

        poke(5'd1, 16'd3);
        issue(mk(OP_ADD, 5'd1, 5'd1, 5'd1, 5'd0), mk(OP_NOT, 5'd6, 5'd1, 5'd0, 5'd0), 1'b1, acc, lat);
        issue(mk(OP_NOT, 5'd6, 5'd1, 5'd0, 5'd0), 32'h0, 1'b0, acc2, lat2);
        chk("alias_add_latency", lat, 5);
        chk("b2b_accept_gap", acc2 - acc, 6);
        chk("not_latency", lat2, 4);
        chk("alias_r1", mem[1], 16'h0006);
        chk("not_r6", mem[6], 16'hFFF9);

        poke(5'd3, 16'd100); poke(5'd4, 16'd7);
        issue(mk(OP_DIV, 5'd1, 5'd3, 5'd4, 5'd0), 32'h0, 1'b0, acc, lat);
        chk("div_latency", lat, 8);
        chk("div_r1", mem[1], 16'h000E);

        // reset in the first EXEC cycle of a MUL
        poke(5'd1, 16'h1111); poke(5'd2, 16'h2222);
        keep1 = 16'h1111; keep2 = 16'h2222;
        instr = mk(OP_MUL, 5'd1, 5'd3, 5'd4, 5'd2); instr_valid = 1'b1;
        acc = -1;
        for (int t = 0; t < 20 && acc < 0; t++) begin
            if (instr_ready) acc = cyc;
            else @(negedge clock);
        end
        if (acc < 0) fail("mul_accept_timeout");
        @(negedge clock);
        instr_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("mul_busy_before_reset", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("post_reset_ready", instr_ready, 1);
        chk("post_reset_busy", busy, 0);
        repeat (4) @(negedge clock);
        chk("abort_r1_kept", mem[1], keep1);
        chk("abort_r2_kept", mem[2], keep2);
        poke(5'd3, 16'd9); poke(5'd4, 16'd30);
        issue(mk(OP_ADD, 5'd8, 5'd3, 5'd4, 5'd0), 32'h0, 1'b0, acc, lat);
        chk("add_after_reset_latency", lat, 5);
        chk("add_after_reset_r8", mem[8], 16'd39);

        for (int k = 0; k < 3000; k++) begin
            reset       = ($urandom_range(0, 249) == 0);
            instr_valid = ($urandom_range(0, 3) != 0);
            instr       = {pick_op(int'($urandom_range(0, 16))), 26'($urandom)};
            @(negedge clock);
        end
        reset = 1'b0;
        instr_valid = 1'b0;
        repeat (20) @(negedge clock);
        for (int i = 0; i < 32; i++) chk($sformatf("final_r%0d", i), mem[i], rmodel[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that accepts one 32-bit instruction word at a time, fetches its operands from the single-port register file, presents them to the combinational ALU datapath, holds them for the op-dependent settle time (MUL and DIV are slow), and writes the result back. It sits between instruction fetch and the ALU/register-file pair. It replaces free-running combinational evaluation with a defined, handshaked sequence.

## Interface
Parameters:
- MUL_LAT, 2, EXEC cycles held for MUL (≥1)
- DIV_LAT, 4, EXEC cycles held for DIV (≥1)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- instr  in  32  instruction word: [31:26] opcode, [25:21] rdst1, [20:16] rsrc1, [15:11] rsrc2, [10:6] rdst2, [15:0] imm
- instr_valid  in  1  instr is valid
- instr_ready  out  1  high only in IDLE
- rf_addr  out  5  register file address (read or write)
- rf_we  out  1  write enable
- rf_wdata  out  16  write data
- rf_rdata  in  16  read data, valid the cycle after rf_addr is presented with rf_we=0
- alu_op  out  6  opcode to ALU
- alu_a, alu_b  out  16 each  ALU operands
- alu_result  in  32  combinational ALU result
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse at instruction completion
- illegal  out  1  high together with done for an unsupported opcode

## Operation
- Opcode classes:
  - Two-operand: ADD 000100, SUB 000101, MUL 000111, DIV 001000, OR 001001, XOR 001010, NAND 001011, NOR 001100, XNOR 001101, LLSH 001111, LRSH 010000.
  - One-operand (a=R[rsrc1], b=0): MOV-reg 000001, NEG 000110, NOT 001110.
  - No-operand: MOV-imm 000000.
  - All other opcodes are illegal.
- Handshake: accept on clock edge with instr_valid & instr_ready. Latch opcode and fields. instr is ignored at all other times.
- States:
  - IDLE: on accept, go to ERR (illegal opcode), EXEC (MOV-imm), or RDA (otherwise).
  - RDA: rf_addr=rsrc1. Go to RDB (two-operand) or CAP.
  - RDB: a ← rf_rdata; rf_addr=rsrc2. Go to CAP.
  - CAP: pending operand ← rf_rdata (b for two-operand, a for one-operand). Go to EXEC.
  - EXEC: alu_op/alu_a/alu_b held constant. Down-counter loaded with MUL_LAT, DIV_LAT or 1. On the last cycle, result ← alu_result (MOV-imm: result={16'b0,imm}; MOV-reg: result={16'b0,a}). Go to WB1.
  - WB1: rf_we=1, rf_addr=rdst1, rf_wdata=result[15:0]. Go to WB2 (MUL) or IDLE with done=1.
  - WB2: rf_we=1, rf_addr=rdst2, rf_wdata=result[31:16]; done=1. Go to IDLE.
  - ERR: done=1, illegal=1, no register write. Go to IDLE.
- Operand order is fixed: alu_a from rsrc1, alu_b from rsrc2. The ALU defines the per-op semantics (e.g. SUB = b + ~a).
- Source and destination may alias. Reads complete before any write, so no hazard exists.
- Register-file writes occur only in WB1/WB2.

## Timing
- Reset values: state=IDLE, instr_ready=1 (after the reset cycle), busy=0, done=0, illegal=0, rf_we=0, rf_addr=0, rf_wdata=0, alu_op/alu_a/alu_b=0, counter=0, a/b/result=0.
- rf_we, done and illegal are forced 0 in any cycle where reset=1. Reset mid-instruction aborts with no further writes. A WB2 after a completed WB1 is lost; this is accepted.
- Latency counted from accept edge T (done cycle):
  - Two-operand, non-MUL/DIV: T+5.
  - One-operand: T+4.
  - MOV-imm: T+2.
  - Illegal: T+1.
  - DIV: T+4+DIV_LAT.
  - MUL: T+5+MUL_LAT.
- Next instruction is accepted on the cycle after done. Minimum issue interval = latency+1.
- instr_valid held high while busy causes no effect; the word is accepted on the first IDLE cycle.

## Test plan
- ADD: R3=5, R4=7, instr ADD rdst1=1 rsrc1=3 rsrc2=4 -> R1=0x000C written at T+5 with done; busy high T+1..T+5.
- MUL: R3=0x1234, R4=0x0100, rdst1=1, rdst2=2, MUL_LAT=2 -> WB1 at T+6 writes R1=0x3400; WB2 at T+7 writes R2=0x0012 with done.
- MOV-imm imm=0xBEEF rdst1=5 -> R5=0xBEEF at T+2. Opcode 111111 -> done&illegal at T+1, no rf_we.
- Aliasing plus back-to-back: R1=3, ADD rdst1=1 rsrc1=1 rsrc2=1, followed by NOT rsrc1=1 rdst1=6 with instr_valid held high -> R1=6; second accept at T+6; R6=0xFFF9 at T+10.
- DIV hold: DIV_LAT=4 -> alu_a/alu_b/alu_op stable for 4 EXEC cycles; done at T+8.
- Reset during EXEC of MUL -> next cycle IDLE, no rf_we pulse, all outputs at reset values; a following ADD completes normally.
